i2s_slave_rx: RTL and testbench
===============================

// Module: i2s_slave_rx
// PURPOSE
//  I2S receiver, slave mode: samples externally driven sck_in/ws_in/sd_in, deserialises
//  left/right words MSB-first, emits one stereo frame {left,right} per I2S frame on an AXI4-Stream master port.
//  Receive-side counterpart of the I2S transmit path; everything runs in the system clock domain (oversampling).
// PARAMETERS
//  WORD_LENGTH  16  bits captured per channel; stereo frame width = 2*WORD_LENGTH
//  SYNC_STAGES  2   flop stages on each of sck_in/ws_in/sd_in (>=2)
// PORTS
//  clk          in   1              system clock; f_clk >= 8*f_sck required
//  rst          in   1              asynchronous, active-high reset
//  sck_in       in   1              I2S bit clock from external master (async)
//  ws_in        in   1              word select, 0=left 1=right (async)
//  sd_in        in   1              serial data (async)
//  axis_data    out  2*WORD_LENGTH  {left[WL-1:0], right[WL-1:0]}
//  axis_valid   out  1              frame available
//  axis_ready   in   1              consumer accepts when valid&ready at posedge clk
//  overflow     out  1              1-clk pulse: completed frame dropped (output register busy)
// BEHAVIOUR
//  Reset: axis_data=0, axis_valid=0, overflow=0, state=SYNC, shift reg/bit count/left_hold/have_left=0.
//  Input conditioning: all three inputs through SYNC_STAGES flops (equal depth, alignment kept);
//   sck rising edge (rise) = synced sck 0->1 between consecutive clk cycles; all bit logic only on rise.
//  Per rise: sample W=ws, D=sd; ws_d holds W of previous rise. Transition T = (W != ws_d).
//   I2S 1-bit delay: bit sampled on the rise where T is seen is the LSB slot of the PREVIOUS channel (ws_d);
//   MSB of new channel arrives on the following rise.
//  Shift: while bit_cnt < WORD_LENGTH, shreg <= {shreg[WL-2:0],D}, bit_cnt++; extra slot bits (bit_cnt==WL) ignored.
//  Word end (rise with T, state RUN): word = shreg incl. this bit, left-justified; short words (bit_cnt<WL)
//   zero-pad LSBs. Then bit_cnt<=0, shreg<=0.
//   ws_d==0 (left ended): left_hold<=word, have_left<=1.
//   ws_d==1 (right ended): if have_left -> frame {left_hold,word} completes; have_left<=0. Else discarded.
//  FSM: SYNC -> RUN on first rise with T (that bit discarded, counter cleared); RUN stays until reset.
//   Words before first transition never output; first frame = first complete left word then right word.
//  Output register (1 entry): frame completes & (!axis_valid | axis_ready) -> load axis_data, axis_valid=1
//   next clk (latency: 1 clk after the rise detecting the right->left transition, plus sync delay).
//   frame completes & axis_valid & !axis_ready -> frame dropped, old frame kept, overflow=1 for one clk.
//   Handshake: axis_valid&axis_ready with no new frame -> axis_valid=0. axis_data stable while valid&!ready.
//  Reset mid-frame: all partial state cleared, returns to SYNC; no partial frame ever emitted.
//  ws glitch / early transition: treated as word end (short word, zero-padded); no resync beyond that.
// CONFIGURATION
//  I2S_RX_ERR_EN defined: extra port frame_err (out,1), reset 0; 1-clk pulse on any RUN word end with
//   bit_cnt<WORD_LENGTH (short word); frame still produced zero-padded.
//  Undefined: no frame_err port; short words silently zero-padded. Datapath identical either way.
// STRUCTURE
//  Shared include i2s_defs.vh: default WORD_LENGTH, ws channel encodings (WS_LEFT=0, WS_RIGHT=1),
//   rx FSM state localparams (RX_SYNC, RX_RUN).
//  Sub-module i2s_in_sync: SYNC_STAGES synchroniser for sck/ws/sd + sck rise detect (outputs ws_s, sd_s, rise).
//  Top: FSM, bit counter, shift reg, left_hold, output register, overflow/err pulses.
// TESTING
//  1 Reset, f_clk=16*f_sck, WL=16, send L=16'hA5C3 R=16'h0F1E repeatedly, ready=1 -> first axis_data=32'hA5C30F1E, one beat per frame.
//  2 Start mid-right word after reset -> no output until full L/R pair; first beat = first complete L + R.
//  3 axis_ready=0 for 3 frames -> first frame held stable, overflow pulses exactly twice, then ready=1 delivers held frame.
//  4 32-bit slots (WL=16), L=32'h12345678 -> captured left=16'h1234 (extra bits ignored).
//  5 12-bit slot at WL=16, L bits=12'hABC -> left=16'hABC0; with I2S_RX_ERR_EN frame_err pulses once.
//  6 Assert rst mid-left word -> axis_valid=0 immediately (async), restart needs new transition; no corrupt frame.

Source files
------------

// File: rtl/i2s_slave_rx_pkg.sv
// Shared definitions for the I2S slave receiver: default word length, ws channel codes and rx FSM states.
package i2s_slave_rx_pkg;

   localparam int DEFAULT_WORD_LENGTH = 16;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   typedef logic [0:0] rx_state_t;

   localparam rx_state_t RX_SYNC = 1'b0;
   localparam rx_state_t RX_RUN  = 1'b1;

endpackage

// File: rtl/i2s_slave_rx_in_sync.sv
// Brings sck/ws/sd into the system clock domain through equal-depth flop chains and flags sck rising edges.
module i2s_in_sync
   import i2s_slave_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck_in,
   input  logic ws_in,
   input  logic sd_in,
   output logic ws_s,
   output logic sd_s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_ws_sync;
   logic [SYNC_STAGES-1:0] r_sd_sync;
   logic                   r_sck_prev;

   // Equal depth on all three chains keeps ws/sd aligned with the sck edge that samples them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_sync <= '0;
         r_ws_sync  <= '0;
         r_sd_sync  <= '0;
         r_sck_prev <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
         r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_in};
         r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sd_in};
         r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
      end
   end

   assign rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
   assign ws_s = r_ws_sync[SYNC_STAGES-1];
   assign sd_s = r_sd_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: deserialises left/right words and emits {left,right} frames on an AXI4-Stream master port.
// Optional build macro I2S_RX_ERR_EN adds a frame_err pulse for short (zero-padded) words.
module i2s_slave_rx
   import i2s_slave_rx_pkg::*;
#(
   parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sck_in,
   input  logic                     ws_in,
   input  logic                     sd_in,
   output logic [2*WORD_LENGTH-1:0] axis_data,
   output logic                     axis_valid,
   input  logic                     axis_ready,
   output logic                     overflow
`ifdef I2S_RX_ERR_EN
   ,
   output logic                     frame_err
`endif
);

   localparam int CW = $clog2(WORD_LENGTH + 1);

   logic                     w_ws_s;
   logic                     w_sd_s;
   logic                     w_rise;
   logic                     w_trans;
   logic                     w_has_room;
   logic [WORD_LENGTH-1:0]   w_shreg_next;
   logic [CW-1:0]            w_cnt_next;
   logic [CW-1:0]            w_pad;
   logic [WORD_LENGTH-1:0]   w_word;
   logic                     w_word_end;
   logic                     w_frame_done;
   logic                     w_accept;

   rx_state_t                r_state;
   logic                     r_ws_d;
   logic [WORD_LENGTH-1:0]   r_shreg;
   logic [CW-1:0]            r_bit_cnt;
   logic [WORD_LENGTH-1:0]   r_left_hold;
   logic                     r_have_left;
   logic [2*WORD_LENGTH-1:0] r_axis_data;
   logic                     r_axis_valid;
   logic                     r_overflow;

   i2s_in_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_in_sync (
      .clk    (clk),
      .rst    (rst),
      .sck_in (sck_in),
      .ws_in  (ws_in),
      .sd_in  (sd_in),
      .ws_s   (w_ws_s),
      .sd_s   (w_sd_s),
      .rise   (w_rise)
   );

   // The bit sampled on a ws transition still belongs to the old channel, so the word
   // is assembled from the shift register including this bit, then left-justified.
   always_comb begin
      w_trans      = (w_ws_s != r_ws_d);
      w_has_room   = (r_bit_cnt < CW'(WORD_LENGTH));
      w_shreg_next = r_shreg;
      w_cnt_next   = r_bit_cnt;
      if (w_has_room) begin
         w_shreg_next = {r_shreg[WORD_LENGTH-2:0], w_sd_s};
         w_cnt_next   = r_bit_cnt + CW'(1);
      end
      w_pad        = CW'(WORD_LENGTH) - w_cnt_next;
      w_word       = w_shreg_next << w_pad;
      w_word_end   = w_rise & w_trans & (r_state == RX_RUN);
      w_frame_done = w_word_end & (r_ws_d == WS_RIGHT) & r_have_left;
      w_accept     = ~r_axis_valid | axis_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RX_SYNC;
         r_ws_d      <= WS_LEFT;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_left_hold <= '0;
         r_have_left <= 1'b0;
      end else if (w_rise) begin
         r_ws_d <= w_ws_s;
         if (w_trans) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            if (r_state == RX_SYNC) begin
               r_state <= RX_RUN;
            end else if (r_ws_d == WS_LEFT) begin
               r_left_hold <= w_word;
               r_have_left <= 1'b1;
            end else begin
               r_have_left <= 1'b0;
            end
         end else begin
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= w_cnt_next;
         end
      end
   end

   // Single-entry output register: a completed frame that finds it occupied is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_axis_data  <= '0;
         r_axis_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_overflow <= 1'b0;
         if (w_frame_done) begin
            if (w_accept) begin
               r_axis_data  <= {r_left_hold, w_word};
               r_axis_valid <= 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end else if (r_axis_valid && axis_ready) begin
            r_axis_valid <= 1'b0;
         end
      end
   end

   assign axis_data  = r_axis_data;
   assign axis_valid = r_axis_valid;
   assign overflow   = r_overflow;

`ifdef I2S_RX_ERR_EN
   logic r_frame_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_word_end & (w_cnt_next < CW'(WORD_LENGTH));
      end
   end

   assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: drives an I2S master stream (sck = clk/16) and checks frames, overflow and reset.
module tb_i2s_slave_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sckIn = 1'b0;
   logic        wsIn = 1'b0;
   logic        sdIn = 1'b0;
   logic [31:0] axisData;
   logic        axisValid;
   logic        axisReady = 1'b1;
   logic        overflow;
`ifdef I2S_RX_ERR_EN
   logic        frameErr;
   int          frameErrCount = 0;
`endif

   int          assertCount = 0;
   int          failCount = 0;
   int          overflowCount = 0;
   logic [31:0] beatQ[$];

   i2s_slave_rx #(
      .WORD_LENGTH(16),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sck_in     (sckIn),
      .ws_in      (wsIn),
      .sd_in      (sdIn),
      .axis_data  (axisData),
      .axis_valid (axisValid),
      .axis_ready (axisReady),
      .overflow   (overflow)
`ifdef I2S_RX_ERR_EN
      ,
      .frame_err  (frameErr)
`endif
   );

   always #5 clk = ~clk;

   // Observe the stream on the falling edge; ready only changes just after a rising edge.
   always @(negedge clk) begin
      if (axisValid && axisReady) beatQ.push_back(axisData);
      if (overflow) overflowCount <= overflowCount + 1;
`ifdef I2S_RX_ERR_EN
      if (frameErr) frameErrCount <= frameErrCount + 1;
`endif
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic sendBit(input logic ws, input logic sd);
      sckIn = 1'b0;
      wsIn  = ws;
      sdIn  = sd;
      repeat (8) @(negedge clk);
      sckIn = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // One channel slot, MSB first; ws switches to the next channel on the slot's last bit.
   task automatic applyStimulus(input logic ws, input logic [31:0] word, input int nbits, input int slot);
      for (int i = 0; i < slot; i++) begin
         sendBit((i == slot - 1) ? ~ws : ws, (i < nbits) ? word[nbits-1-i] : 1'b0);
      end
   endtask

   task automatic setReady(input logic value);
      @(posedge clk);
      #1 axisReady = value;
   endtask

   task automatic doReset();
      sckIn = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [31:0] beatAt(input int idx);
      if (idx < beatQ.size()) return beatQ[idx];
      return 32'hxxxxxxxx;
   endfunction

   initial begin
      int base;
      int ovfBase;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", axisValid, 1'b0);
      checkOutput("reset_data", axisData, 32'h0);
      checkOutput("reset_overflow", overflow, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Test 1: steady stream, one beat per frame
      $display("[TB] test 1: steady stream");
      base = beatQ.size();
      applyStimulus(1'b0, 32'h0000, 16, 16);
      applyStimulus(1'b1, 32'h0F1E, 16, 16);
      checkOutput("t1_no_beat_before_pair", beatQ.size() - base, 0);
      for (int f = 0; f < 3; f++) begin
         applyStimulus(1'b0, 32'hA5C3, 16, 16);
         applyStimulus(1'b1, 32'h0F1E, 16, 16);
      end
      repeat (6) @(negedge clk);
      checkOutput("t1_beat_count", beatQ.size() - base, 3);
      checkOutput("t1_first_beat", beatAt(base), 32'hA5C30F1E);
      checkOutput("t1_last_beat", beatAt(base + 2), 32'hA5C30F1E);

      // Test 2: start mid-right word after reset
      $display("[TB] test 2: start mid-right word");
      doReset();
      base = beatQ.size();
      applyStimulus(1'b1, 32'h55, 7, 7);
      applyStimulus(1'b0, 32'h2468, 16, 16);
      applyStimulus(1'b1, 32'hACE1, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t2_beat_count", beatQ.size() - base, 1);
      checkOutput("t2_first_beat", beatAt(base), 32'h2468ACE1);

      // Test 3: back-pressure for three frames
      $display("[TB] test 3: back-pressure");
      setReady(1'b0);
      base = beatQ.size();
      ovfBase = overflowCount;
      applyStimulus(1'b0, 32'h1111, 16, 16);
      applyStimulus(1'b1, 32'h2222, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t3_valid_held", axisValid, 1'b1);
      checkOutput("t3_data_f1", axisData, 32'h11112222);
      applyStimulus(1'b0, 32'h3333, 16, 16);
      applyStimulus(1'b1, 32'h4444, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t3_data_after_f2", axisData, 32'h11112222);
      checkOutput("t3_overflow_one", overflowCount - ovfBase, 1);
      applyStimulus(1'b0, 32'h5555, 16, 16);
      applyStimulus(1'b1, 32'h6666, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t3_data_after_f3", axisData, 32'h11112222);
      checkOutput("t3_overflow_two", overflowCount - ovfBase, 2);
      checkOutput("t3_no_beat_while_stalled", beatQ.size() - base, 0);
      setReady(1'b1);
      repeat (4) @(negedge clk);
      checkOutput("t3_beat_count", beatQ.size() - base, 1);
      checkOutput("t3_beat_data", beatAt(base), 32'h11112222);
      checkOutput("t3_valid_cleared", axisValid, 1'b0);

      // Test 4: 32-bit slots, extra bits ignored
      $display("[TB] test 4: 32-bit slots");
      base = beatQ.size();
      applyStimulus(1'b0, 32'h12345678, 32, 32);
      applyStimulus(1'b1, 32'h9ABCDEF0, 32, 32);
      repeat (6) @(negedge clk);
      checkOutput("t4_beat_count", beatQ.size() - base, 1);
      checkOutput("t4_beat_data", beatAt(base), 32'h12349ABC);

      // Test 5: 12-bit left slot, zero-padded
      $display("[TB] test 5: short left word");
      base = beatQ.size();
`ifdef I2S_RX_ERR_EN
      ovfBase = frameErrCount;
`endif
      applyStimulus(1'b0, 32'hABC, 12, 12);
      applyStimulus(1'b1, 32'h1357, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t5_beat_count", beatQ.size() - base, 1);
      checkOutput("t5_beat_data", beatAt(base), 32'hABC01357);
`ifdef I2S_RX_ERR_EN
      checkOutput("t5_frame_err_count", frameErrCount - ovfBase, 1);
`endif

      // Test 6: reset mid-left word with a frame held
      $display("[TB] test 6: reset mid-frame");
      setReady(1'b0);
      applyStimulus(1'b0, 32'hAAAA, 16, 16);
      applyStimulus(1'b1, 32'hBBBB, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t6_valid_before_reset", axisValid, 1'b1);
      for (int i = 0; i < 8; i++) sendBit(1'b0, i[0]);
      sckIn = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("t6_valid_async_clear", axisValid, 1'b0);
      checkOutput("t6_data_async_clear", axisData, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      setReady(1'b1);
      base = beatQ.size();
      for (int i = 0; i < 7; i++) sendBit(1'b0, ~i[0]);
      sendBit(1'b1, 1'b1);
      applyStimulus(1'b1, 32'hDEAD, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t6_no_partial_frame", beatQ.size() - base, 0);
      applyStimulus(1'b0, 32'h600D, 16, 16);
      applyStimulus(1'b1, 32'hF00D, 16, 16);
      repeat (6) @(negedge clk);
      checkOutput("t6_beat_count", beatQ.size() - base, 1);
      checkOutput("t6_beat_data", beatAt(base), 32'h600DF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
